// File: rtl/conv_loop_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_loop_sequencer_if
//   Bundles the four request/done handshakes between the convolution loop
//   sequencer and the units it drives.
//
//   Signals (master = sequencer, slave = the external units):
//     ld_w_req / ld_w_co / ld_w_ci / ld_w_done      weight loader
//     ld_i_req / ld_i_row / ld_i_ci / ld_i_done     input-row loader
//     comp_req / comp_row / comp_ci / comp_first /
//     comp_last / comp_done                         compute array
//     wr_o_req / wr_o_row / wr_o_co / wr_o_done     output writer
//
//   Parameter ROW_W sets the width of every row index.
// ---------------------------------------------------------------------------
interface conv_loop_sequencer_if #(
  parameter int ROW_W = 6
);
  // Weight loader
  logic             ld_w_req;
  logic [1:0]       ld_w_co;
  logic [1:0]       ld_w_ci;
  logic             ld_w_done;

  // Input-row loader
  logic             ld_i_req;
  logic [ROW_W-1:0] ld_i_row;
  logic [1:0]       ld_i_ci;
  logic             ld_i_done;

  // Compute array
  logic             comp_req;
  logic [ROW_W-1:0] comp_row;
  logic [1:0]       comp_ci;
  logic             comp_first;
  logic             comp_last;
  logic             comp_done;

  // Output writer
  logic             wr_o_req;
  logic [ROW_W-1:0] wr_o_row;
  logic [1:0]       wr_o_co;
  logic             wr_o_done;

  modport master (
    output ld_w_req, ld_w_co, ld_w_ci,
    input  ld_w_done,
    output ld_i_req, ld_i_row, ld_i_ci,
    input  ld_i_done,
    output comp_req, comp_row, comp_ci, comp_first, comp_last,
    input  comp_done,
    output wr_o_req, wr_o_row, wr_o_co,
    input  wr_o_done
  );

  modport slave (
    input  ld_w_req, ld_w_co, ld_w_ci,
    output ld_w_done,
    input  ld_i_req, ld_i_row, ld_i_ci,
    output ld_i_done,
    input  comp_req, comp_row, comp_ci, comp_first, comp_last,
    output comp_done,
    input  wr_o_req, wr_o_row, wr_o_co,
    output wr_o_done
  );
endinterface

// File: rtl/conv_loop_sequencer.sv
// ---------------------------------------------------------------------------
// conv_loop_sequencer
//   Top-level sequencer of the convolution engine. On an accepted start it
//   latches the channel-group configuration and walks the loop nest
//     co -> { weight loads for every ci,
//             row -> { (input-row load, compute) for every ci, write } }
//   issuing one handshake at a time to the external units, then pulses
//   end_conv for one cycle.
//
//   Ports:
//     clk, rst_n        clock (rising edge) and async active-low reset
//     start_conv        start request, only looked at while idle
//     cfg_ci, cfg_co    input / output channel groups minus one
//     busy              high from the first run cycle through DONE
//     end_conv          one-cycle completion pulse (DONE state)
//     bus               handshakes to the four external units (master side)
//
//   Parameters:
//     ROWS              feature rows per output channel group (>= 2)
//     ROW_W             width of the row index, clog2(ROWS)
// ---------------------------------------------------------------------------
module conv_loop_sequencer #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_conv,
  input  logic [1:0]             cfg_ci,
  input  logic [1:0]             cfg_co,
  output logic                   busy,
  output logic                   end_conv,
  conv_loop_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_W,
    S_LD_I,
    S_COMP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t           r_state;
  logic [1:0]       r_co;
  logic [1:0]       r_ci;
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_cfg_ci;
  logic [1:0]       r_cfg_co;

  state_t           w_state_nxt;
  logic [1:0]       w_co_nxt;
  logic [1:0]       w_ci_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_latch_cfg;

  // State, loop counters and the configuration captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_co     <= '0;
      r_ci     <= '0;
      r_row    <= '0;
      r_cfg_ci <= '0;
      r_cfg_co <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_co    <= w_co_nxt;
      r_ci    <= w_ci_nxt;
      r_row   <= w_row_nxt;
      if (w_latch_cfg) begin
        r_cfg_ci <= cfg_ci;
        r_cfg_co <= cfg_co;
      end
    end
  end

  // Loop-nest walk. Each handshake state only reacts to its own done, so a
  // done arriving while another unit is being served has no effect.
  always_comb begin
    w_state_nxt = r_state;
    w_co_nxt    = r_co;
    w_ci_nxt    = r_ci;
    w_row_nxt   = r_row;
    w_latch_cfg = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_conv) begin
          w_state_nxt = S_LD_W;
          w_co_nxt    = '0;
          w_ci_nxt    = '0;
          w_row_nxt   = '0;
          w_latch_cfg = 1'b1;
        end
      end
      S_LD_W: begin
        if (bus.ld_w_done) begin
          if (r_ci < r_cfg_ci) begin
            w_ci_nxt = r_ci + 2'd1;
          end else begin
            w_ci_nxt    = '0;
            w_row_nxt   = '0;
            w_state_nxt = S_LD_I;
          end
        end
      end
      S_LD_I: begin
        if (bus.ld_i_done) begin
          w_state_nxt = S_COMP;
        end
      end
      S_COMP: begin
        if (bus.comp_done) begin
          if (r_ci < r_cfg_ci) begin
            w_ci_nxt    = r_ci + 2'd1;
            w_state_nxt = S_LD_I;
          end else begin
            w_ci_nxt    = '0;
            w_state_nxt = S_WR;
          end
        end
      end
      S_WR: begin
        if (bus.wr_o_done) begin
          if (r_row < ROW_LAST) begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = S_LD_I;
          end else if (r_co < r_cfg_co) begin
            w_co_nxt    = r_co + 2'd1;
            w_row_nxt   = '0;
            w_state_nxt = S_LD_W;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Requests decode from state alone; indices follow the counters at all
  // times. first/last are gated with the compute request so they read zero
  // whenever compute is not active (including straight out of reset).
  always_comb begin
    busy     = (r_state != S_IDLE);
    end_conv = (r_state == S_DONE);

    bus.ld_w_req = (r_state == S_LD_W);
    bus.ld_w_co  = r_co;
    bus.ld_w_ci  = r_ci;

    bus.ld_i_req = (r_state == S_LD_I);
    bus.ld_i_row = r_row;
    bus.ld_i_ci  = r_ci;

    bus.comp_req   = (r_state == S_COMP);
    bus.comp_row   = r_row;
    bus.comp_ci    = r_ci;
    bus.comp_first = (r_state == S_COMP) && (r_ci == 2'd0);
    bus.comp_last  = (r_state == S_COMP) && (r_ci == r_cfg_ci);

    bus.wr_o_req = (r_state == S_WR);
    bus.wr_o_row = r_row;
    bus.wr_o_co  = r_co;
  end

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_loop_sequencer
//   Self-checking bench for conv_loop_sequencer. Instance A uses ROWS=64 and
//   is served by a responder that either ties every done high or answers
//   after a random 0-7 cycle delay with spurious dones in between. Instance B
//   uses ROWS=2 with all dones tied high. Every completed handshake is logged
//   and compared against the loop nest generated directly from the config.
// ---------------------------------------------------------------------------
module tb_conv_loop_sequencer;

  localparam int ROWS_A = 64;
  localparam int RW_A   = 6;
  localparam int ROWS_B = 2;
  localparam int RW_B   = 1;
  localparam int RUN_LIMIT = 20000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       startA = 1'b0;
  logic [1:0] cfgCiA = 2'd0;
  logic [1:0] cfgCoA = 2'd0;
  logic       busyA;
  logic       endA;

  logic       startB = 1'b0;
  logic [1:0] cfgCiB = 2'd0;
  logic [1:0] cfgCoB = 2'd0;
  logic       busyB;
  logic       endB;

  conv_loop_sequencer_if #(.ROW_W(RW_A)) ifA ();
  conv_loop_sequencer_if #(.ROW_W(RW_B)) ifB ();

  conv_loop_sequencer #(.ROWS(ROWS_A), .ROW_W(RW_A)) dutA (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_conv (startA),
    .cfg_ci     (cfgCiA),
    .cfg_co     (cfgCoA),
    .busy       (busyA),
    .end_conv   (endA),
    .bus        (ifA)
  );

  conv_loop_sequencer #(.ROWS(ROWS_B), .ROW_W(RW_B)) dutB (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_conv (startB),
    .cfg_ci     (cfgCiB),
    .cfg_co     (cfgCoB),
    .busy       (busyB),
    .end_conv   (endB),
    .bus        (ifB)
  );

  always #5 clk = ~clk;

  // Every DUT output packed together, for "everything is zero" checks.
  logic [18+3*RW_A-1:0] outsA;
  logic [18+3*RW_B-1:0] outsB;
  assign outsA = {busyA, endA, ifA.ld_w_req, ifA.ld_w_co, ifA.ld_w_ci,
                  ifA.ld_i_req, ifA.ld_i_row, ifA.ld_i_ci,
                  ifA.comp_req, ifA.comp_row, ifA.comp_ci, ifA.comp_first, ifA.comp_last,
                  ifA.wr_o_req, ifA.wr_o_row, ifA.wr_o_co};
  assign outsB = {busyB, endB, ifB.ld_w_req, ifB.ld_w_co, ifB.ld_w_ci,
                  ifB.ld_i_req, ifB.ld_i_row, ifB.ld_i_ci,
                  ifB.comp_req, ifB.comp_row, ifB.comp_ci, ifB.comp_first, ifB.comp_last,
                  ifB.wr_o_req, ifB.wr_o_row, ifB.wr_o_co};

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] logA[$];
  logic [31:0] logB[$];
  logic [31:0] expQ[$];

  bit         rndMode  = 1'b0;
  int         dropCnt  = 0;
  int         endCntA  = 0;
  logic [3:0] armed    = 4'd0;
  int         latCnt[4];

  // One handshake event: unit (0=W,1=I,2=C,3=O), two indices, first/last.
  function automatic logic [31:0] mkEv(int unit, int a, int b, bit first, bit last);
    logic [3:0] u;
    u = 4'(unit);
    return {u, 2'b00, first, last, 8'(a), 8'(b), 8'h00};
  endfunction

  // Reference handshake order straight from the loop nest.
  task automatic buildExp(input int ci, input int co, input int rows);
    expQ.delete();
    for (int o = 0; o <= co; o++) begin
      for (int i = 0; i <= ci; i++) expQ.push_back(mkEv(0, o, i, 1'b0, 1'b0));
      for (int r = 0; r < rows; r++) begin
        for (int i = 0; i <= ci; i++) begin
          expQ.push_back(mkEv(1, r, i, 1'b0, 1'b0));
          expQ.push_back(mkEv(2, r, i, i == 0, i == ci));
        end
        expQ.push_back(mkEv(3, r, o, 1'b0, 1'b0));
      end
    end
  endtask

  // Number of positions where the logged order departs from expQ.
  task automatic diffSeq(input bit useB, output int errs, output int firstIdx,
                         output logic [31:0] gotV, output logic [31:0] expV);
    logic [31:0] q[$];
    if (useB) q = logB;
    else      q = logA;
    errs = 0; firstIdx = -1; gotV = '0; expV = '0;
    for (int i = 0; i < expQ.size(); i++) begin
      logic [31:0] g;
      g = (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
      if (g !== expQ[i]) begin
        if (errs == 0) begin firstIdx = i; gotV = g; expV = expQ[i]; end
        errs++;
      end
    end
    if (q.size() > expQ.size()) errs += q.size() - expQ.size();
  endtask

  // Responder for instance A: drives dones at the falling edge and logs
  // every handshake that will complete at the following rising edge.
  always @(negedge clk) begin : respA
    logic [3:0] reqV;
    logic [3:0] doneV;
    reqV  = {ifA.wr_o_req, ifA.comp_req, ifA.ld_i_req, ifA.ld_w_req};
    doneV = 4'd0;
    if (!rst_n) begin
      armed = 4'd0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (!rndMode) begin
          doneV[u] = 1'b1;
        end else if (!reqV[u]) begin
          if (armed[u]) dropCnt++;
          armed[u] = 1'b0;
          doneV[u] = 1'($urandom_range(0, 1));
        end else begin
          if (!armed[u]) begin
            armed[u]  = 1'b1;
            latCnt[u] = $urandom_range(0, 7);
          end
          if (latCnt[u] == 0) begin
            doneV[u] = 1'b1;
            armed[u] = 1'b0;
          end else begin
            latCnt[u]--;
          end
        end
        if (doneV[u] && reqV[u]) begin
          case (u)
            0: logA.push_back(mkEv(0, ifA.ld_w_co, ifA.ld_w_ci, 1'b0, 1'b0));
            1: logA.push_back(mkEv(1, ifA.ld_i_row, ifA.ld_i_ci, 1'b0, 1'b0));
            2: logA.push_back(mkEv(2, ifA.comp_row, ifA.comp_ci, ifA.comp_first, ifA.comp_last));
            default: logA.push_back(mkEv(3, ifA.wr_o_row, ifA.wr_o_co, 1'b0, 1'b0));
          endcase
        end
      end
    end
    ifA.ld_w_done = doneV[0];
    ifA.ld_i_done = doneV[1];
    ifA.comp_done = doneV[2];
    ifA.wr_o_done = doneV[3];
  end

  always @(negedge clk) begin
    if (endA) endCntA++;
  end

  // Instance B has every done tied high, so each request cycle is a handshake.
  initial begin
    ifB.ld_w_done = 1'b1;
    ifB.ld_i_done = 1'b1;
    ifB.comp_done = 1'b1;
    ifB.wr_o_done = 1'b1;
  end

  always @(negedge clk) begin
    if (ifB.ld_w_req) logB.push_back(mkEv(0, ifB.ld_w_co, ifB.ld_w_ci, 1'b0, 1'b0));
    if (ifB.ld_i_req) logB.push_back(mkEv(1, ifB.ld_i_row, ifB.ld_i_ci, 1'b0, 1'b0));
    if (ifB.comp_req) logB.push_back(mkEv(2, ifB.comp_row, ifB.comp_ci, ifB.comp_first, ifB.comp_last));
    if (ifB.wr_o_req) logB.push_back(mkEv(3, ifB.wr_o_row, ifB.wr_o_co, 1'b0, 1'b0));
  end

  // Starts a run on instance A (unless already started) and returns at the
  // falling edge inside the end_conv cycle, counting the first busy cycle as 1.
  task automatic runToEnd(input bit preStarted, input int ci, input int co, input bit midStart,
                          output int endCyc, output bit busyDrop, output bit timedOut);
    int cyc;
    if (!preStarted) begin
      @(negedge clk);
      cfgCiA = 2'(ci);
      cfgCoA = 2'(co);
      startA = 1'b1;
      logA.delete();
    end
    @(negedge clk);
    startA   = 1'b0;
    cyc      = 1;
    busyDrop = 1'b0;
    timedOut = 1'b0;
    while (!endA) begin
      if (!busyA) busyDrop = 1'b1;
      if (midStart && cyc == 20) begin
        startA = 1'b1;
        cfgCiA = ~2'(ci);
        cfgCoA = ~2'(co);
      end
      if (midStart && cyc == 21) startA = 1'b0;
      if (cyc >= RUN_LIMIT) begin
        timedOut = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!busyA) busyDrop = 1'b1;
    endCyc = cyc;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    compared++;
    if (outsA !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outs_a: got %h expected 0", outsA);
    end
    compared++;
    if (outsB !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outs_b: got %h expected 0", outsB);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if ({busyA, busyB} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got busy %b expected 00", {busyA, busyB});
    end
  endtask

  task automatic test_tied_run(input int ci, input int co, input string name);
    int endCyc, expEnd, errs, idx;
    bit bDrop, tOut;
    logic [31:0] g, e;
    rndMode = 1'b0;
    buildExp(ci, co, ROWS_A);
    expEnd = (co + 1) * ((ci + 1) + ROWS_A * (2 * (ci + 1) + 1)) + 1;
    runToEnd(1'b0, ci, co, 1'b0, endCyc, bDrop, tOut);
    compared++;
    if (tOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no end_conv within %0d cycles", name, RUN_LIMIT);
    end
    compared++;
    if (endCyc !== expEnd) begin
      mismatched++;
      $display("[TB] FAIL %s_end_cycle: got %0d expected %0d", name, endCyc, expEnd);
    end
    compared++;
    if (bDrop !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_busy: got busy low during run, expected high", name);
    end
    diffSeq(1'b0, errs, idx, g, e);
    compared++;
    if (errs !== 0) begin
      mismatched++;
      $display("[TB] FAIL %s_order: %0d bad events, first at %0d got %h expected %h (logged %0d of %0d)",
               name, errs, idx, g, e, logA.size(), expQ.size());
    end
    @(negedge clk);
    compared++;
    if ({busyA, endA} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL %s_after_end: got busy/end %b expected 00", name, {busyA, endA});
    end
  endtask

  task automatic test_random_latency();
    int ci, co, endCyc, errs, idx;
    bit bDrop, tOut;
    logic [31:0] g, e;
    rndMode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ci = $urandom_range(0, 3);
      co = $urandom_range(0, 3);
      buildExp(ci, co, ROWS_A);
      dropCnt = 0;
      runToEnd(1'b0, ci, co, 1'b0, endCyc, bDrop, tOut);
      compared++;
      if ((tOut | bDrop) !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL rnd%0d_run: got timeout %b busy-drop %b expected 0 0", k, tOut, bDrop);
      end
      diffSeq(1'b0, errs, idx, g, e);
      compared++;
      if (errs !== 0) begin
        mismatched++;
        $display("[TB] FAIL rnd%0d_order cfg %0d/%0d: %0d bad events, first at %0d got %h expected %h",
                 k, ci, co, errs, idx, g, e);
      end
      compared++;
      if (dropCnt !== 0) begin
        mismatched++;
        $display("[TB] FAIL rnd%0d_req_hold: got %0d requests dropped before done expected 0", k, dropCnt);
      end
    end
    rndMode = 1'b0;
  endtask

  task automatic test_start_ignored();
    int endCyc, errs, idx;
    bit bDrop, tOut;
    logic [31:0] g, e;
    rndMode = 1'b1;
    buildExp(1, 1, ROWS_A);
    runToEnd(1'b0, 1, 1, 1'b1, endCyc, bDrop, tOut);
    diffSeq(1'b0, errs, idx, g, e);
    compared++;
    if ((errs !== 0) || tOut) begin
      mismatched++;
      $display("[TB] FAIL ign_order: %0d bad events, first at %0d got %h expected %h, timeout %b",
               errs, idx, g, e, tOut);
    end
    // Start raised during the DONE cycle must not launch a run.
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    compared++;
    if ({busyA, ifA.ld_w_req} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL ign_done_start: got busy/ld_w_req %b expected 00", {busyA, ifA.ld_w_req});
    end
    @(negedge clk);
    compared++;
    if (busyA !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ign_done_start_late: got busy %b expected 0", busyA);
    end
    rndMode = 1'b0;
  endtask

  task automatic test_back_to_back();
    int endCyc, expEnd, errs, idx;
    bit bDrop, tOut;
    logic [31:0] g, e;
    rndMode = 1'b0;
    runToEnd(1'b0, 2, 0, 1'b0, endCyc, bDrop, tOut);
    compared++;
    if (tOut !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2b_first_timeout: got no end_conv expected one");
    end
    // First IDLE cycle after DONE: this start is accepted.
    @(negedge clk);
    cfgCiA = 2'd0;
    cfgCoA = 2'd1;
    startA = 1'b1;
    logA.delete();
    buildExp(0, 1, ROWS_A);
    expEnd = 2 * (1 + ROWS_A * 3) + 1;
    runToEnd(1'b1, 0, 1, 1'b0, endCyc, bDrop, tOut);
    compared++;
    if ((endCyc !== expEnd) || bDrop) begin
      mismatched++;
      $display("[TB] FAIL b2b_second_run: got end cycle %0d busy-drop %b expected %0d 0", endCyc, bDrop, expEnd);
    end
    diffSeq(1'b0, errs, idx, g, e);
    compared++;
    if (errs !== 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_order: %0d bad events, first at %0d got %h expected %h", errs, idx, g, e);
    end
  endtask

  task automatic test_reset_mid();
    int endBefore;
    bit found;
    rndMode = 1'b0;
    @(negedge clk);
    cfgCiA = 2'd0;
    cfgCoA = 2'd0;
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    found  = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (ifA.comp_req && (ifA.comp_row == 6'd10)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (found !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_reach: got no compute at row 10 expected one");
    end
    endBefore = endCntA;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (outsA !== '0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_async: got %h expected 0", outsA);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if ((endCntA !== endBefore) || (busyA !== 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_quiet: got end pulses %0d busy %b expected 0 0",
               endCntA - endBefore, busyA);
    end
  endtask

  task automatic test_rows2();
    int cyc, expEnd, errs, idx;
    logic [31:0] g, e;
    buildExp(1, 0, ROWS_B);
    expEnd = 1 * ((1 + 1) + ROWS_B * (2 * (1 + 1) + 1)) + 1;
    @(negedge clk);
    cfgCiB = 2'd1;
    cfgCoB = 2'd0;
    startB = 1'b1;
    logB.delete();
    @(negedge clk);
    startB = 1'b0;
    cyc    = 1;
    while (!endB && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (cyc !== expEnd) begin
      mismatched++;
      $display("[TB] FAIL rows2_end_cycle: got %0d expected %0d", cyc, expEnd);
    end
    diffSeq(1'b1, errs, idx, g, e);
    compared++;
    if (errs !== 0) begin
      mismatched++;
      $display("[TB] FAIL rows2_order: %0d bad events, first at %0d got %h expected %h", errs, idx, g, e);
    end
    @(negedge clk);
    compared++;
    if (busyB !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rows2_after_end: got busy %b expected 0", busyB);
    end
  endtask

  initial begin
    test_reset();
    test_tied_run(0, 0, "base");
    test_tied_run(3, 1, "wide");
    test_random_latency();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_tied_run(1, 0, "after_reset");
    test_rows2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_loop_sequencer.md
# conv_loop_sequencer

Top-level sequencer for the convolution engine. It accepts a start pulse and a latched channel configuration, then walks the output-channel / row / input-channel loop nest. For each step it issues request/done handshakes to four external units in order:
- weight loader, which fills the 4 kernel-row slots;
- input-row loader, which fills the feature-row buffer;
- compute array;
- output writer.

It signals completion with a one-cycle end pulse.

## Interface
Parameters:
- ROWS, 64, feature rows per output channel group (≥2)
- ROW_W, 6, width of row index (clog2(ROWS))

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_conv  in  1  start request; sampled only in IDLE
- cfg_ci  in  2  input-channel groups minus 1 (1..4 groups)
- cfg_co  in  2  output-channel groups minus 1 (1..4 groups)
- busy  out  1  run in progress
- end_conv  out  1  one-cycle completion pulse
- ld_w_req  out  1  weight load request (level)
- ld_w_co  out  2  output group to load
- ld_w_ci  out  2  input group / kernel slot to load
- ld_w_done  in  1  weight load finished
- ld_i_req  out  1  input-row load request (level)
- ld_i_row  out  ROW_W  row index
- ld_i_ci  out  2  input group
- ld_i_done  in  1  input-row load finished
- comp_req  out  1  compute request (level)
- comp_row  out  ROW_W  row index
- comp_ci  out  2  kernel slot to use
- comp_first  out  1  comp_ci==0: clear accumulator
- comp_last  out  1  comp_ci==cfg_ci latched
- comp_done  in  1  compute finished
- wr_o_req  out  1  output write request (level)
- wr_o_row  out  ROW_W  row index
- wr_o_co  out  2  output group
- wr_o_done  in  1  write finished

## Operation
- States: IDLE, LD_W, LD_I, COMP, WR, DONE. Counters co (2b), ci (2b), row (ROW_W).
- Latched config: on start_conv in IDLE, cfg_ci/cfg_co are latched, counters are cleared, and the state goes to LD_W. cfg inputs are ignored for the rest of the run.
- start_conv outside IDLE is ignored and is not queued.

Loop order:
- For each co from 0 to cfg_co:
  - LD_W once per ci from 0 to cfg_ci.
  - Then for each row from 0 to ROWS-1:
    - For each ci from 0 to cfg_ci: LD_I, then COMP.
    - Then WR.
- After the WR of the last row of the last co, go to DONE, then IDLE.

Transitions:
- LD_W + ld_w_done: if ci<cfg_ci, ci++ and stay in LD_W. Otherwise ci=0, row=0, go to LD_I.
- LD_I + ld_i_done: go to COMP.
- COMP + comp_done: if ci<cfg_ci, ci++ and go to LD_I. Otherwise ci=0 and go to WR.
- WR + wr_o_done:
  - If row<ROWS-1, row++ and go to LD_I.
  - Else if co<cfg_co, co++, row=0, go to LD_W.
  - Otherwise go to DONE.
- DONE: unconditionally go to IDLE.

Request and output rules:
- Each *_req is decoded from state alone and is high for every cycle spent in its state.
- A done input is honoured only in its own state. Done inputs in any other state are ignored.
- Index outputs carry the current counters whenever their req is high. They are don't-care otherwise but are driven from the counters.
- No counter wraps mid-run; every terminal compare uses the latched cfg and ROWS-1.

## Timing
- Reset (async assert, sync release): state=IDLE, counters=0, latched cfg=0. All outputs are 0: busy, end_conv, every *_req, all indices, comp_first, comp_last.
- start_conv sampled high at edge E: busy and ld_w_req go high in the cycle after E.
- Each handshake state lasts at least 1 cycle. A done sampled high at an edge ends that state at the same edge, and the next req is visible in the following cycle.
- busy is high from the cycle after acceptance through the DONE cycle inclusive. end_conv is high only in the DONE cycle.
- With all done inputs tied high, the run takes N = (cfg_co+1)·((cfg_ci+1) + ROWS·(2·(cfg_ci+1)+1)) handshake cycles. end_conv is high in cycle N+1, counting the first busy cycle as cycle 1.
- A start_conv in the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted.
- rst_n asserted mid-run clears everything immediately. No end_conv is generated.

## Test plan
- Config 0/0, ROWS=64, all done tied high -> exactly 1 ld_w, then 64×(ld_i, comp, wr) with rows 0..63 in order; comp_first=comp_last=1 on every comp; end_conv in cycle 194; busy low in cycle 195.
- Config cfg_ci=3, cfg_co=1, done tied high -> 8 ld_w (co 0 then 1, ci 0..3), 512 ld_i, 512 comp, 128 wr; comp_first only at ci=0, comp_last only at ci=3; end_conv in cycle 1161.
- Random done latencies of 0–7 extra cycles, plus spurious done pulses in non-matching states -> order and counts are identical to the tied-high run; no extra transitions; each req is held until its own done.
- start_conv pulsed mid-run and in the DONE cycle, with cfg changed mid-run -> both starts ignored; the run completes with the original cfg; a start one cycle after DONE begins a new run.
- rst_n asserted during COMP at row 10 -> all outputs 0 asynchronously; no end_conv; the next start runs from co=0, ci=0, row=0.
- ROWS=2 parameter override, config 1/0 -> order is ld_w ci0, ld_w ci1, then for row 0 and row 1: ld_i ci0, comp ci0, ld_i ci1, comp ci1, wr; end_conv in cycle 13.
